inst_ram_loader: RTL and testbench

- Initiator for the CPU's debug instruction-RAM load interface (debug, inst_ram_write_enable/data/address).
- Accepts a byte stream with a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit words, writes them to consecutive instruction-RAM addresses, and holds the CPU in reset while loading.
- When loading finishes, releases the CPU to run from the freshly loaded program.

---
 rtl/inst_ram_loader.sv | 158 +++++++++++++++
 tb/tb_inst_ram_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_loader.sv
// Debug instruction-RAM loader: receives a length-prefixed little-endian byte stream,
// writes the words to consecutive instruction-RAM addresses, then releases the CPU from reset.
module inst_ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        debug,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       len_lo;
  logic [31:0]       word_total;
  logic [31:0]       word_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic        accept;
  logic [31:0] len_full;
  logic        len_bad;

  assign accept   = byte_valid && byte_ready;
  // Length bytes 0..2 are shifted in from the top, so the final byte completes the word here.
  assign len_full = {byte_data, len_lo};
  assign len_bad  = (len_full == '0) || (len_full > MAX_WORDS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= S_IDLE;
      byte_ready             <= 1'b1;
      debug                  <= 1'b0;
      inst_ram_write_enable  <= 1'b0;
      inst_ram_write_data    <= '0;
      inst_ram_write_address <= BASE_ADDR;
      cpu_reset              <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
      byte_cnt               <= '0;
      len_lo                 <= '0;
      word_total             <= '0;
      word_cnt               <= '0;
      idle_cnt               <= '0;
      hold_cnt               <= '0;
    end else begin
      inst_ram_write_enable <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (accept) begin
            state                  <= S_LEN;
            byte_cnt               <= 2'd1;
            len_lo                 <= {byte_data, len_lo[23:8]};
            debug                  <= 1'b1;
            cpu_reset              <= 1'b0;
            done                   <= 1'b0;
            error                  <= 1'b0;
            inst_ram_write_address <= BASE_ADDR;
            word_cnt               <= '0;
            idle_cnt               <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_bad) begin
                state <= S_ERROR;
                debug <= 1'b0;
                error <= 1'b1;
              end else begin
                word_total <= len_full;
                state      <= S_DATA;
              end
            end else begin
              len_lo <= {byte_data, len_lo[23:8]};
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state <= S_ERROR;
            debug <= 1'b0;
            error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        S_DATA: begin
          if (accept) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            inst_ram_write_data[{byte_cnt, 3'b000} +: 8] <= byte_data;
            if (byte_cnt == 2'd3) begin
              state                 <= S_WRITE;
              inst_ram_write_enable <= 1'b1;
              byte_ready            <= 1'b0;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state <= S_ERROR;
            debug <= 1'b0;
            error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        S_WRITE: begin
          word_cnt               <= word_cnt + 32'd1;
          inst_ram_write_address <= inst_ram_write_address + 32'd4;
          if (word_cnt + 32'd1 == word_total) begin
            state    <= S_RELEASE;
            debug    <= 1'b0;
            hold_cnt <= '0;
          end else begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            cpu_reset  <= 1'b1;
            done       <= 1'b1;
            byte_ready <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Scoreboard bench for inst_ram_loader: a frame-level model predicts RAM writes and load outcome,
// a negedge monitor pops expected writes and checks handshake/release behaviour every cycle.
module tb_inst_ram_loader;

  localparam logic [31:0] TB_BASE    = 32'h0000_1000;
  localparam int unsigned TB_MAX     = 1024;
  localparam int unsigned TB_TIMEOUT = 16;
  localparam int unsigned TB_HOLD    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        debug;
  logic        inst_ram_write_enable;
  logic [31:0] inst_ram_write_data;
  logic [31:0] inst_ram_write_address;
  logic        cpu_reset;
  logic        done;
  logic        error;

  inst_ram_loader #(
    .BASE_ADDR (TB_BASE),
    .MAX_WORDS (TB_MAX),
    .TIMEOUT   (TB_TIMEOUT),
    .RST_HOLD  (TB_HOLD)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .byte_valid             (byte_valid),
    .byte_data              (byte_data),
    .byte_ready             (byte_ready),
    .debug                  (debug),
    .inst_ram_write_enable  (inst_ram_write_enable),
    .inst_ram_write_data    (inst_ram_write_data),
    .inst_ram_write_address (inst_ram_write_address),
    .cpu_reset              (cpu_reset),
    .done                   (done),
    .error                  (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  typedef enum {OUT_DONE, OUT_LEN_ERR, OUT_TIMEOUT} outcome_t;

  wr_t         exp_q[$];
  logic [7:0]  frame[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rel_left = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level reference: decode N, cut the payload into words, decide how the load ends.
  task automatic predict(output outcome_t oc);
    logic [31:0] n;
    int          avail;
    int unsigned nw;
    wr_t         e;
    n = {frame[3], frame[2], frame[1], frame[0]};
    if (n == 0 || n > TB_MAX) begin
      oc = OUT_LEN_ERR;
      return;
    end
    avail = (int'(frame.size()) - 4) / 4;
    nw = (avail < int'(n)) ? avail : n;
    for (int unsigned k = 0; k < nw; k++) begin
      e.addr = TB_BASE + 32'(4 * k);
      e.data = {frame[4*k+7], frame[4*k+6], frame[4*k+5], frame[4*k+4]};
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    oc = (avail >= int'(n)) ? OUT_DONE : OUT_TIMEOUT;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned w;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    w = 0;
    while (!byte_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!byte_ready) check("byte_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int unsigned from, input int unsigned to, input int unsigned max_gap);
    for (int unsigned i = from; i < to; i++)
      send_byte(frame[i], $urandom_range(max_gap, 0));
  endtask

  task automatic expect_outcome(input outcome_t oc);
    case (oc)
      OUT_DONE: begin
        repeat (TB_HOLD) @(negedge clk);
        check("hold_cpu_reset", 32'(cpu_reset), 32'd0);
        check("hold_done", 32'(done), 32'd0);
        @(negedge clk);
        check("run_cpu_reset", 32'(cpu_reset), 32'd1);
        check("run_done", 32'(done), 32'd1);
        check("run_error", 32'(error), 32'd0);
        check("run_debug", 32'(debug), 32'd0);
      end
      OUT_LEN_ERR: begin
        check("len_error", 32'(error), 32'd1);
        check("len_debug", 32'(debug), 32'd0);
        check("len_cpu_reset", 32'(cpu_reset), 32'd0);
        check("len_done", 32'(done), 32'd0);
      end
      default: begin
        repeat (TB_TIMEOUT - 1) @(negedge clk);
        check("pre_timeout_error", 32'(error), 32'd0);
        check("pre_timeout_debug", 32'(debug), 32'd1);
        @(negedge clk);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_debug", 32'(debug), 32'd0);
        check("timeout_cpu_reset", 32'(cpu_reset), 32'd0);
        check("timeout_done", 32'(done), 32'd0);
      end
    endcase
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input int unsigned max_gap);
    outcome_t oc;
    predict(oc);
    send_range(0, frame.size(), max_gap);
    expect_outcome(oc);
  endtask

  task automatic random_frame(input int unsigned n);
    logic [31:0] nv;
    nv = n;
    frame = {nv[7:0], nv[15:8], nv[23:16], nv[31:24]};
    for (int unsigned i = 0; i < 4 * n; i++) frame.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic check_reset_values();
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_debug", 32'(debug), 32'd0);
    check("rst_write_enable", 32'(inst_ram_write_enable), 32'd0);
    check("rst_write_data", inst_ram_write_data, 32'd0);
    check("rst_write_address", inst_ram_write_address, TB_BASE);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  // Monitor: byte_ready low exactly on write strobes and release-hold cycles; writes match the queue.
  always @(negedge clk) begin
    if (!reset) begin
      rel_left = 0;
    end else begin
      check("byte_ready", 32'(byte_ready),
            (inst_ram_write_enable || rel_left != 0) ? 32'd0 : 32'd1);
      if (rel_left != 0) begin
        check("release_debug", 32'(debug), 32'd0);
        check("release_cpu_reset", 32'(cpu_reset), 32'd0);
        check("release_no_write", 32'(inst_ram_write_enable), 32'd0);
        rel_left--;
      end
      if (inst_ram_write_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", inst_ram_write_address, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_address", inst_ram_write_address, e.addr);
          check("write_data", inst_ram_write_data, e.data);
          check("write_debug", 32'(debug), 32'd1);
          if (e.last) rel_left = TB_HOLD;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    outcome_t oc;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(0);

    frame = {8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(0);

    frame = {8'h01, 8'h04, 8'h00, 8'h00};
    run_frame(0);

    // N = MAX_WORDS is legal: one word lands, then a partial word times out.
    frame = {8'h00, 8'h04, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55};
    run_frame(0);

    frame = {8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    run_frame(0);

    frame = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(0);

    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(5);

    for (int r = 0; r < 4; r++) begin
      random_frame($urandom_range(4, 1));
      run_frame((r % 2 == 0) ? 5 : 0);
    end

    // Asynchronous reset in the middle of word 2.
    frame = {8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    predict(oc);
    send_range(0, frame.size(), 0);
    #2 reset = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clk);
    check("reset_hold_no_write", 32'(inst_ram_write_enable), 32'd0);
    reset = 1'b1;
    check("reset_queue_drained", exp_q.size(), 32'd0);
    @(negedge clk);

    random_frame(1);
    run_frame(0);

    // Reload from RUN: first accepted byte must pull the CPU back into reset.
    random_frame(2);
    predict(oc);
    send_range(0, 1, 0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd0);
    check("reload_debug", 32'(debug), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    send_range(1, frame.size(), 0);
    expect_outcome(oc);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
